// File: rtl/hyper_titan_pkg.sv
// Shared types and constants for the e-core launch controller: FSM state
// encoding, register byte offsets and CTRL/STATUS bit positions.
package hyper_titan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4,
    ST_TIMEOUT = 3'd5
  } ecore_state_e;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CYCLES = 4'h8;
  localparam logic [3:0] ADDR_WDT    = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_KICK   = 3;
  localparam int CTRL_CLEAR  = 4;

  localparam int STAT_DONE    = 4;
  localparam int STAT_FAULT   = 5;
  localparam int STAT_TIMEOUT = 6;
  localparam int STAT_WFI     = 7;

endpackage

// File: rtl/hyper_titan_ecore_regs.sv
// Register decode, CTRL command pulses, IRQ_EN/WDT_LIMIT storage and the
// registered read path. WDT_LIMIT exists only with HYPER_TITAN_ECORE_WDT_EN.
module hyper_titan_ecore_regs
  import hyper_titan_pkg::*;
#(
  parameter logic [31:0] WDT_DEFAULT = 32'h000F_FFFF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [3:0]   addr_i,
  input  logic [31:0]  wdata_i,
  input  ecore_state_e state,
  input  logic         done_flag,
  input  logic         fault_flag,
  input  logic         timeout_flag,
  input  logic         wfi_i,
  input  logic [31:0]  cycles,
  output logic         start,
  output logic         abort,
  output logic         kick,
  output logic         clear,
  output logic         irq_en,
  output logic [31:0]  wdt_limit,
  output logic         rvalid_o,
  output logic [31:0]  rdata_o
);

  logic        ctrl_wr;
  logic [31:0] rd_mux;

  assign ctrl_wr = req_i & we_i & (addr_i == ADDR_CTRL);
  assign start   = ctrl_wr & wdata_i[CTRL_START];
  assign abort   = ctrl_wr & wdata_i[CTRL_ABORT];
  assign kick    = ctrl_wr & wdata_i[CTRL_KICK];
  assign clear   = ctrl_wr & wdata_i[CTRL_CLEAR];

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      ADDR_STATUS: rd_mux = {24'd0, wfi_i, timeout_flag, fault_flag, done_flag, 1'b0, state};
      ADDR_CYCLES: rd_mux = cycles;
      ADDR_WDT:    rd_mux = wdt_limit;
      default:     rd_mux = '0;
    endcase
  end

  // IRQ_EN is set-only from software; only rst_i clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      irq_en   <= 1'b0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i) ? rd_mux : 32'd0;
      if (ctrl_wr && wdata_i[CTRL_IRQ_EN]) irq_en <= 1'b1;
    end
  end

`ifdef HYPER_TITAN_ECORE_WDT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      wdt_limit <= WDT_DEFAULT;
    else if (req_i && we_i && addr_i == ADDR_WDT)
      wdt_limit <= wdata_i;
  end
`else
  logic [26:0] unused_wdata;
  logic [31:0] unused_wdt_default;
  assign wdt_limit          = '0;
  assign unused_wdata       = wdata_i[31:5];
  assign unused_wdt_default = WDT_DEFAULT;
`endif

endmodule

// File: rtl/hyper_titan_ecore_ctrl.sv
// E-core launch controller: reset sequencing, run-cycle counting, completion
// status and interrupts. Define HYPER_TITAN_ECORE_WDT_EN for the run watchdog.
module hyper_titan_ecore_ctrl
  import hyper_titan_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16,
  parameter logic [31:0] WDT_DEFAULT = 32'h000F_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        halted_i,
  input  logic        fault_i,
  input  logic        wfi_i,
  output logic        ecore_rst_no,
  output logic        ecore_irq_o,
  output logic        p_irq_o
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

  ecore_state_e state;
  logic [7:0]   rst_cnt;
  logic [31:0]  cycles;
  logic         done_flag, fault_flag, timeout_flag;
  logic         start, abort, kick, clear, irq_en;
  logic [31:0]  wdt_limit;

  assign gnt_o = req_i;

  hyper_titan_ecore_regs #(.WDT_DEFAULT(WDT_DEFAULT)) u_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .state        (state),
    .done_flag    (done_flag),
    .fault_flag   (fault_flag),
    .timeout_flag (timeout_flag),
    .wfi_i        (wfi_i),
    .cycles       (cycles),
    .start        (start),
    .abort        (abort),
    .kick         (kick),
    .clear        (clear),
    .irq_en       (irq_en),
    .wdt_limit    (wdt_limit),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o)
  );

`ifndef HYPER_TITAN_ECORE_WDT_EN
  logic [31:0] unused_wdt_limit;
  assign unused_wdt_limit = wdt_limit;
`endif

  // CYCLES only advances while RUN is held, so an exit cycle leaves it frozen
  // at the value that was compared against the watchdog limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      cycles       <= '0;
      done_flag    <= 1'b0;
      fault_flag   <= 1'b0;
      timeout_flag <= 1'b0;
      ecore_rst_no <= 1'b0;
      ecore_irq_o  <= 1'b0;
      p_irq_o      <= 1'b0;
    end else begin
      ecore_irq_o <= kick && (state == ST_RUN) && !abort;
      p_irq_o     <= irq_en & (done_flag | fault_flag | timeout_flag);
      case (state)
        ST_IDLE: begin
          ecore_rst_no <= 1'b0;
          if (start) begin
            state        <= ST_RESET;
            rst_cnt      <= RST_LOAD;
            cycles       <= '0;
            done_flag    <= 1'b0;
            fault_flag   <= 1'b0;
            timeout_flag <= 1'b0;
          end
        end
        ST_RESET: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (rst_cnt == 8'd0) begin
            state        <= ST_RUN;
            ecore_rst_no <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state        <= ST_IDLE;
            ecore_rst_no <= 1'b0;
          end else if (fault_i) begin
            state      <= ST_FAULT;
            fault_flag <= 1'b1;
          end else if (halted_i) begin
            state     <= ST_DONE;
            done_flag <= 1'b1;
          end
`ifdef HYPER_TITAN_ECORE_WDT_EN
          else if (wdt_limit != 32'd0 && cycles == wdt_limit) begin
            state        <= ST_TIMEOUT;
            timeout_flag <= 1'b1;
          end
`endif
          else if (cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
          end
        end
        ST_DONE, ST_FAULT, ST_TIMEOUT: begin
          if (clear) begin
            state        <= ST_IDLE;
            ecore_rst_no <= 1'b0;
            done_flag    <= 1'b0;
            fault_flag   <= 1'b0;
            timeout_flag <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          ecore_rst_no <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hyper_titan_ecore_ctrl.md
HYPER_TITAN_ECORE_CTRL -- requirements
Module: hyper_titan_ecore_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles the e-core reset is held low during launch (2..255).
REQ-002 SHALL have parameter WDT_DEFAULT, default 32'h000F_FFFF: reset value of the WDT_LIMIT register.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  block clock, same as e-core io_aclk.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_i  in  1  p-core register request; we_i  in  1  write enable; addr_i  in  4  byte address; wdata_i  in  32  write data.
REQ-007 gnt_o  out  1  request accepted; rvalid_o  out  1  response valid; rdata_o  out  32  read data.
REQ-008 halted_i  in  1  e-core io_halted; fault_i  in  1  e-core io_fault; wfi_i  in  1  e-core io_wfi.
REQ-009 ecore_rst_no  out  1  drives e-core io_aresetn; ecore_irq_o  out  1  drives e-core io_irq.
REQ-010 p_irq_o  out  1  completion interrupt to p-core irq_i.

Function
REQ-011 gnt_o SHALL equal req_i (always ready).
REQ-012 rvalid_o SHALL pulse exactly one cycle after each granted request; rdata_o is valid with it and is 0 for writes.
REQ-013 Register map: 0x0 CTRL (W: bit0 START, bit1 ABORT, bit2 IRQ_EN sticky, bit3 KICK, bit4 CLEAR); 0x4 STATUS (R: [2:0] state, bit4 DONE, bit5 FAULT, bit6 TIMEOUT, bit7 wfi_i); 0x8 CYCLES (R); 0xC WDT_LIMIT (RW). Unmapped reads return 0; unmapped writes are ignored.
REQ-014 FSM states: IDLE=0, RESET=1, RUN=2, DONE=3, FAULT=4, TIMEOUT=5.
REQ-015 IDLE: START -> RESET; the RESET counter loads RST_CYCLES-1 and CYCLES clears to 0.
REQ-016 RESET: ecore_rst_no=0; counter decrements; at 0 -> RUN on the next cycle.
REQ-017 RUN: ecore_rst_no=1; CYCLES increments each cycle, saturating at 32'hFFFF_FFFF.
REQ-018 RUN exits: fault_i -> FAULT; else halted_i -> DONE; fault_i wins if both are high in the same cycle.
REQ-019 DONE, FAULT and TIMEOUT SHALL hold ecore_rst_no=1 and freeze CYCLES; CLEAR -> IDLE.
REQ-020 ecore_rst_no SHALL be 0 in IDLE.
REQ-021 ABORT in RESET or RUN -> IDLE the next cycle; ABORT takes priority over START, KICK and e-core status in the same cycle.
REQ-022 START outside IDLE SHALL be ignored; CLEAR outside DONE, FAULT and TIMEOUT SHALL be ignored.
REQ-023 KICK in RUN SHALL produce a one-cycle ecore_irq_o pulse, registered one cycle after the write; it is ignored in all other states.
REQ-024 DONE, FAULT and TIMEOUT status bits SHALL be sticky, set on state entry, and cleared by CLEAR or START.
REQ-025 p_irq_o SHALL be registered and equal IRQ_EN & (DONE|FAULT|TIMEOUT).
REQ-026 A write to WDT_LIMIT during RUN SHALL take effect on the next compare.

Reset
REQ-027 On rst_i: state=IDLE; ecore_rst_no=0; ecore_irq_o=0; p_irq_o=0; rvalid_o=0; rdata_o=0; CYCLES=0; IRQ_EN=0; sticky status bits=0; WDT_LIMIT=WDT_DEFAULT.
REQ-028 rst_i asserted mid-RUN SHALL drive ecore_rst_no low on the following edge and discard any pending response.

Configuration
REQ-029 With HYPER_TITAN_ECORE_WDT_EN defined: in RUN, when CYCLES == WDT_LIMIT and neither halted_i nor fault_i is high -> TIMEOUT; WDT_LIMIT=0 disables the watchdog.
REQ-030 Without HYPER_TITAN_ECORE_WDT_EN: no TIMEOUT transition; the WDT_LIMIT register is absent (reads 0, writes ignored); STATUS bit6 reads 0.

Structure
REQ-031 Package hyper_titan_pkg SHALL hold the state enum ecore_state_e, the register offset constants and the CTRL/STATUS bit-index constants.
REQ-032 The register decode and read mux SHALL be a sub-module, hyper_titan_ecore_regs; the FSM and counters stay in the top module.

Verification
REQ-033 RST_CYCLES=16, write CTRL=0x1 -> ecore_rst_no low for exactly 16 cycles, then high; STATUS[2:0]=2.
REQ-034 In RUN, after 100 cycles assert halted_i -> STATUS=0x13, CYCLES=100±1 and frozen; with IRQ_EN set, p_irq_o=1; CTRL=0x10 -> IDLE, p_irq_o=0.
REQ-035 halted_i and fault_i high in the same cycle -> STATE=FAULT, STATUS bit5=1, bit4=0.
REQ-036 WDT_EN defined, WDT_LIMIT=50, no halt -> TIMEOUT at CYCLES=50; with WDT_LIMIT=0 -> stays in RUN for more than 1000 cycles.
REQ-037 CTRL=0x8 in RUN -> one-cycle ecore_irq_o pulse; the same write in IDLE -> no pulse.
REQ-038 CTRL=0x3 (ABORT+START) in RUN -> IDLE with ecore_rst_no=0; rst_i mid-RUN -> all outputs at reset values the next cycle.
